// File: rtl/gpio_input.sv
// gpio_input: input side of the GPIO block, sharing the CSR bus with the
// GPIO output register.
//
// Function: 32 pins go through a two-flop synchroniser and a per-pin
// debouncer clocked by a programmable sample tick. Edges of the debounced
// value set a sticky W1C PENDING register, and PENDING & MASK drive a
// registered level interrupt.
//
// Optional feature macro: GPIO_INPUT_DEBOUNCE_EN
//   defined   : prescaler, 3-deep per-pin sample shifters and DIVIDER register
//   undefined : debounced value follows sync2 every cycle, DIVIDER reads 0
//
// Ports:
//   sys_clk     system clock, rising edge
//   sys_rst_n   asynchronous active-low reset
//   csr_a       CSR address, [13:10] bank, [3:0] register
//   csr_we      CSR write strobe
//   csr_di      CSR write data
//   csr_do      registered CSR read data (0 when bank not selected)
//   gpio_inputs raw asynchronous pin levels
//   irq         registered level interrupt
//
// Register map: 0 IN (ro), 1 PENDING (w1c), 2 MASK, 3 RISE_EN, 4 FALL_EN,
//               5 DIVIDER [15:0]; other offsets read 0.

module gpio_input_lane (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic tick,
  input  logic pin,
  output logic deb,
  output logic deb_nxt
);
  logic sync1, sync2;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_INPUT_DEBOUNCE_EN
  logic [2:0] sh;
  logic       stable;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sh <= 3'b000;
    else if (tick)  sh <= {sh[1:0], sync2};
  end

  // Only a value seen on three consecutive ticks is accepted.
  assign stable  = (sh == 3'b000) || (sh == 3'b111);
  assign deb_nxt = stable ? sh[0] : deb;
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign deb_nxt     = sync2;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) deb <= 1'b0;
    else            deb <= deb_nxt;
  end
endmodule

module gpio_input #(
  parameter logic [3:0] csr_addr = 4'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic [31:0] gpio_inputs,
  output logic        irq
);
  localparam int NUM_LANES = 32;

  logic                 sel, wr, tick;
  logic [NUM_LANES-1:0] deb, deb_nxt, pending, mask, rise_en, fall_en;
  logic [NUM_LANES-1:0] set, clr;
  logic [31:0]          rd_data;
  logic                 unused_a;

  assign sel      = (csr_a[13:10] == csr_addr);
  assign wr       = sel & csr_we;
  assign unused_a = ^csr_a[9:4];

`ifdef GPIO_INPUT_DEBOUNCE_EN
  logic [15:0] divider, presc;

  // Down-counter reloads from DIVIDER on reaching 0; a DIVIDER write only
  // takes effect at the next reload.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)          presc <= '0;
    else if (presc == 16'd0) presc <= divider;
    else                     presc <= presc - 16'd1;
  end
  assign tick = (presc == 16'd0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                        divider <= '0;
    else if (wr && csr_a[3:0] == 4'h5)     divider <= csr_di[15:0];
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    gpio_input_lane u_lane (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .tick      (tick),
      .pin       (gpio_inputs[i]),
      .deb       (deb[i]),
      .deb_nxt   (deb_nxt[i])
    );
  end

  assign set = (~deb & deb_nxt & rise_en) | (deb & ~deb_nxt & fall_en);
  assign clr = (wr && csr_a[3:0] == 4'h1) ? csr_di : '0;

  always_comb begin
    rd_data = '0;
    case (csr_a[3:0])
      4'h0:    rd_data = deb;
      4'h1:    rd_data = pending;
      4'h2:    rd_data = mask;
      4'h3:    rd_data = rise_en;
      4'h4:    rd_data = fall_en;
`ifdef GPIO_INPUT_DEBOUNCE_EN
      4'h5:    rd_data = {16'h0, divider};
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csr_do  <= '0;
      irq     <= 1'b0;
      pending <= '0;
      mask    <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else begin
      csr_do  <= sel ? rd_data : '0;
      irq     <= |(pending & mask);
      // set after clear: a new edge wins over a same-cycle W1C
      pending <= (pending & ~clr) | set;
      if (wr) begin
        case (csr_a[3:0])
          4'h2:    mask    <= csr_di;
          4'h3:    rise_en <= csr_di;
          4'h4:    fall_en <= csr_di;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gpio_input.sv
module tb_gpio_input;
  localparam logic [3:0] BANK = 4'h5;
`ifdef GPIO_INPUT_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [13:0] csr_a = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic [31:0] gpio_inputs = '0;
  logic        irq;

  always #5 sys_clk = ~sys_clk;

  gpio_input #(.csr_addr(BANK)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .csr_a       (csr_a),
    .csr_we      (csr_we),
    .csr_di      (csr_di),
    .csr_do      (csr_do),
    .gpio_inputs (gpio_inputs),
    .irq         (irq)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  // ---------------- reference model (spec rules, per clock edge) ----------
  logic [31:0] m_in, m_pend, m_mask, m_rise, m_fall, m_do;
  logic [15:0] m_div;
  logic        m_irq;
  logic [31:0] hist[$];   // pin values presented at past edges, oldest first
`ifdef GPIO_INPUT_DEBOUNCE_EN
  logic [31:0] samp[$];   // tick samples, newest first
  int          edge_no, next_tick;
`endif

  task automatic model_reset();
    m_in = '0; m_pend = '0; m_mask = '0; m_rise = '0; m_fall = '0;
    m_do = '0; m_div = '0; m_irq = 1'b0;
    hist.delete();
`ifdef GPIO_INPUT_DEBOUNCE_EN
    samp.delete();
    repeat (3) samp.push_back('0);
    edge_no = 0; next_tick = 1;
`endif
  endtask

  task automatic model_edge(input logic [13:0] a, input logic we,
                            input logic [31:0] di, input logic [31:0] pin);
    logic [31:0] seen, dn, set, clr, rd;
    logic        sel;
    // value that has crossed both synchroniser stages: pin from two edges ago
    seen = (hist.size() >= 2) ? hist[hist.size()-2] : 32'h0;
`ifdef GPIO_INPUT_DEBOUNCE_EN
    begin
      logic [31:0] agree;
      edge_no++;
      agree = ~(samp[0] ^ samp[1]) & ~(samp[1] ^ samp[2]);
      dn = (m_in & ~agree) | (samp[0] & agree);
      if (edge_no == next_tick) begin
        samp.push_front(seen);
        void'(samp.pop_back());
        next_tick = edge_no + int'(m_div) + 1;
      end
    end
`else
    dn = seen;
`endif
    sel = (a[13:10] == BANK);
    case (a[3:0])
      4'h0: rd = m_in;
      4'h1: rd = m_pend;
      4'h2: rd = m_mask;
      4'h3: rd = m_rise;
      4'h4: rd = m_fall;
`ifdef GPIO_INPUT_DEBOUNCE_EN
      4'h5: rd = {16'h0, m_div};
`endif
      default: rd = '0;
    endcase
    set   = (~m_in & dn & m_rise) | (m_in & ~dn & m_fall);
    clr   = (sel && we && a[3:0] == 4'h1) ? di : '0;
    m_do  = sel ? rd : '0;
    m_irq = |(m_pend & m_mask);
    m_pend = (m_pend & ~clr) | set;
    m_in  = dn;
    if (sel && we) begin
      case (a[3:0])
        4'h2: m_mask = di;
        4'h3: m_rise = di;
        4'h4: m_fall = di;
`ifdef GPIO_INPUT_DEBOUNCE_EN
        4'h5: m_div  = di[15:0];
`endif
        default: ;
      endcase
    end
    hist.push_back(pin);
    if (hist.size() > 3) void'(hist.pop_front());
  endtask

  // ---------------- stimulus helpers ----------------
  logic [31:0] pins = '0;

  function automatic logic [13:0] ad(input logic [3:0] r);
    return {BANK, 6'b0, r};
  endfunction

  // one clock: drive, edge, model, compare outputs, return at negedge
  task automatic cyc(input logic [13:0] a, input logic we, input logic [31:0] di);
    csr_a = a; csr_we = we; csr_di = di; gpio_inputs = pins;
    @(posedge sys_clk);
    model_edge(a, we, di, pins);
    #1;
    chk("csr_do", csr_do, m_do);
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
    @(negedge sys_clk);
  endtask

  task automatic wr(input logic [3:0] r, input logic [31:0] v);
    cyc(ad(r), 1'b1, v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(ad(4'h0), 1'b0, '0);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] r, input logic [31:0] exp);
    cyc(ad(r), 1'b0, '0);
    chk(tag, csr_do, exp);
  endtask

  task automatic async_reset();
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_do", csr_do, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int first_in, first_irq;
    model_reset();
    // T1: reset state
    #1 sys_rst_n = 1'b0;
    #1;
    chk("por_do", csr_do, 32'h0);
    chk("por_irq", {31'b0, irq}, 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int r = 0; r < 6; r++) rd_chk("reset_reg", 4'(r), 32'h0);
    rd_chk("off7", 4'h7, 32'h0);
    cyc({BANK ^ 4'h1, 6'b0, 4'h2}, 1'b1, 32'hFFFF);   // other bank: ignored
    rd_chk("other_bank_wr", 4'h2, 32'h0);
    wr(4'h2, 32'hA5);
    cyc({BANK ^ 4'h1, 6'b0, 4'h2}, 1'b0, '0);
    chk("other_bank_rd", csr_do, 32'h0);
    rd_chk("mask_rd", 4'h2, 32'hA5);
    wr(4'h0, 32'hFFFF_FFFF);
    rd_chk("in_ro", 4'h0, 32'h0);

    // T2: latency of a rising edge
    wr(4'h5, 32'h0); wr(4'h3, 32'h1); wr(4'h2, 32'h1);
    idle(2);
    pins[0] = 1'b1;
    first_in = 0; first_irq = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc(ad(4'h0), 1'b0, '0);
      if (first_in == 0 && csr_do[0]) first_in = n;
      if (first_irq == 0 && irq) first_irq = n;
    end
    chk("t2_in_edge", 32'(first_in), 32'(LAT + 1));
    chk("t2_irq_edge", 32'(first_irq), 32'(LAT + 1));
    rd_chk("t2_pend", 4'h1, 32'h1);

`ifdef GPIO_INPUT_DEBOUNCE_EN
    // T3: short pulse rejected, long pulse accepted
    wr(4'h3, 32'h21); wr(4'h5, 32'h3);
    idle(8);
    pins[5] = 1'b1; idle(8); pins[5] = 1'b0;
    idle(30);
    cyc(ad(4'h0), 1'b0, '0); chk("t3_short_in", csr_do & 32'h20, 32'h0);
    cyc(ad(4'h1), 1'b0, '0); chk("t3_short_pend", csr_do & 32'h20, 32'h0);
    pins[5] = 1'b1; idle(16);
    idle(20);
    cyc(ad(4'h0), 1'b0, '0); chk("t3_long_in", csr_do & 32'h20, 32'h20);
    wr(4'h5, 32'h0);
    idle(6);
`endif

    // T4: set wins over same-edge W1C on bit 31
    pins[31] = 1'b1; idle(LAT + 3);
    wr(4'h1, 32'hFFFF_FFFF);
    wr(4'h4, 32'h8000_0000); wr(4'h2, 32'h8000_0000);
    idle(2);
    pins[31] = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      if (i == LAT) wr(4'h1, 32'h8000_0000);
      else          idle(1);
    end
    cyc(ad(4'h1), 1'b0, '0); chk("t4_set_wins", csr_do & 32'h8000_0000, 32'h8000_0000);
    chk("t4_irq_on", {31'b0, irq}, 32'h1);
    wr(4'h1, 32'h8000_0000);
    chk("t4_irq_hold", {31'b0, irq}, 32'h1);
    idle(1);
    chk("t4_irq_off", {31'b0, irq}, 32'h0);

    // T5: masking drops irq, pending kept
    pins[1:0] = 2'b00; idle(LAT + 2);
    wr(4'h1, 32'hFFFF_FFFF); wr(4'h3, 32'h3);
    pins[1:0] = 2'b11; idle(LAT + 2);
    rd_chk("t5_pend", 4'h1, 32'h3);
    wr(4'h2, 32'h2); idle(1);
    chk("t5_irq_on", {31'b0, irq}, 32'h1);
    wr(4'h2, 32'h0); idle(1);
    chk("t5_irq_off", {31'b0, irq}, 32'h0);
    rd_chk("t5_pend_kept", 4'h1, 32'h3);

    // T6: asynchronous reset mid-debounce
    wr(4'h3, 32'hFF);
    pins[7:0] = 8'h00; idle(LAT + 2);
    wr(4'h1, 32'hFFFF_FFFF);
    pins[7:0] = 8'hFF; idle(LAT + 2);
    rd_chk("t6_pend", 4'h1, 32'hFF);
    wr(4'h2, 32'hFF);
    pins = 32'h1;
    cyc(ad(4'h1), 1'b0, '0); cyc(ad(4'h1), 1'b0, '0);
    chk("t6_irq_pre", {31'b0, irq}, 32'h1);
    async_reset();
    for (int r = 0; r < 6; r++) rd_chk("t6_reg", 4'(r), 32'h0);
    idle(LAT);
    rd_chk("t6_in_after", 4'h0, 32'h1);
    rd_chk("t6_pend_after", 4'h1, 32'h0);

    // DIVIDER storage
    wr(4'h5, 32'h1234);
`ifdef GPIO_INPUT_DEBOUNCE_EN
    rd_chk("div_rd", 4'h5, 32'h1234);
    wr(4'h5, 32'h0);
    idle(4);
`else
    rd_chk("div_rd", 4'h5, 32'h0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [3:0]  r;
      logic [31:0] d;
      pins = pins ^ ($urandom & $urandom & $urandom & $urandom);
      r = 4'($urandom_range(0, 7));
      d = $urandom;
      if (r == 4'h5) d = d & 32'h7;
      case ($urandom_range(0, 9))
        0, 1, 2: cyc(ad(r), 1'b1, d);
        3:       cyc({BANK ^ 4'($urandom_range(1, 15)), 6'b0, r}, $urandom_range(0, 1) == 1, d);
        default: cyc(ad(r), 1'b0, '0);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
